// File: rtl/cmp_ctrl_pkg.sv
// Shared types and helpers for the byte-sequential magnitude comparator.
package cmp_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

    // Number of bytes walked for an operand of the given width.
    function automatic int unsigned nbytes(input int unsigned width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/cmp8_slice.sv
// Combinational 8-bit compare slice; signed_mode treats both bytes as two's complement.
module cmp8_slice
    import cmp_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              signed_mode,
    output cmp_res_t          res_c
);

    // Exactly one of eq/gt/lt is set for any input pair.
    always_comb begin
        res_c = '0;
        if (a == b) begin
            res_c.eq = 1'b1;
        end else if (signed_mode) begin
            res_c.gt = ($signed(a) > $signed(b));
            res_c.lt = ~res_c.gt;
        end else begin
            res_c.gt = (a > b);
            res_c.lt = ~res_c.gt;
        end
    end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequencing controller: latches an operand pair and walks it MSB byte first
// through a single 8-bit compare slice, then offers eq/gt/lt to the consumer.
// Optional feature macro: CMP_SEQ_EARLY_EXIT_EN (finish on the first mismatching
// byte instead of always spending NBYTES cycles in CMP).
module cmp_seq_ctrl
    import cmp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int unsigned NBYTES = nbytes(WIDTH);
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    cmp_state_t        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [WIDTH-1:0]  a_q, a_nxt;
    logic [WIDTH-1:0]  b_q, b_nxt;
    cmp_res_t          res_q, res_nxt;
    cmp_res_t          slice_res;
`ifndef CMP_SEQ_EARLY_EXIT_EN
    logic              found_q, found_nxt;
    cmp_res_t          first_q, first_nxt;
`endif

    logic [BYTE_W-1:0] a_bytes [NBYTES];
    logic [BYTE_W-1:0] b_bytes [NBYTES];
    logic              signed_mode;

    // Byte k of the operand, k=0 being the most significant byte.
    for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
        assign a_bytes[g] = a_q[WIDTH-1-g*BYTE_W -: BYTE_W];
        assign b_bytes[g] = b_q[WIDTH-1-g*BYTE_W -: BYTE_W];
    end

    // Only the most significant byte carries the sign.
    assign signed_mode = (SIGNED != 0) && (idx == '0);

    cmp8_slice u_slice (
        .a           (a_bytes[idx]),
        .b           (b_bytes[idx]),
        .signed_mode (signed_mode),
        .res_c       (slice_res)
    );

    // Next-state and datapath update; the first mismatching byte decides the result.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_nxt     = a_q;
        b_nxt     = b_q;
        res_nxt   = res_q;
`ifndef CMP_SEQ_EARLY_EXIT_EN
        found_nxt = found_q;
        first_nxt = first_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    idx_nxt   = '0;
                    state_nxt = CMP;
`ifndef CMP_SEQ_EARLY_EXIT_EN
                    found_nxt = 1'b0;
                    first_nxt = '0;
`endif
                end
            end
            CMP: begin
`ifdef CMP_SEQ_EARLY_EXIT_EN
                if (!slice_res.eq || (idx == IDX_LAST)) begin
                    res_nxt   = slice_res;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
`else
                if (!found_q && !slice_res.eq) begin
                    found_nxt = 1'b1;
                    first_nxt = slice_res;
                end
                if (idx == IDX_LAST) begin
                    // With no earlier mismatch the last slice result is the answer (eq or not).
                    res_nxt   = found_q ? first_q : slice_res;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifndef CMP_SEQ_EARLY_EXIT_EN
            found_q   <= 1'b0;
            first_q   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            res_q     <= res_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
`ifndef CMP_SEQ_EARLY_EXIT_EN
            found_q   <= found_nxt;
            first_q   <= first_nxt;
`endif
        end
    end

    assign eq = res_q.eq;
    assign gt = res_q.gt;
    assign lt = res_q.lt;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl: an unsigned and a signed instance share stimulus.
module tb_cmp_seq_ctrl;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NBYTES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a, b;
    logic             out_ready;
    logic in_ready_u, out_valid_u, eq_u, gt_u, lt_u, busy_u;
    logic in_ready_s, out_valid_s, eq_s, gt_s, lt_s, busy_s;

    always #5 clk = ~clk;

    cmp_seq_ctrl #(.WIDTH(WIDTH), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready),
        .eq(eq_u), .gt(gt_u), .lt(lt_u), .busy(busy_u)
    );

    cmp_seq_ctrl #(.WIDTH(WIDTH), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .eq(eq_s), .gt(gt_s), .lt(lt_s), .busy(busy_s)
    );

    typedef struct {
        logic [2:0] res_u;
        logic [2:0] res_s;
        int         lat;
        int         hs_neg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   neg_cnt = 0;
    int   hs_cnt = 0;
    logic tied = 1'b0;

    // Reference: whole-word compare; latency from count of leading equal bytes.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [31:0] x;
        int          k;
        e.res_u = (av == bv) ? 3'b100 : (av > bv) ? 3'b010 : 3'b001;
        e.res_s = (av == bv) ? 3'b100 : ($signed(av) > $signed(bv)) ? 3'b010 : 3'b001;
        x = av ^ bv;
        k = 0;
        while (k < NBYTES && x[31:24] == 8'h00) begin
            x = x << 8;
            k++;
        end
`ifdef CMP_SEQ_EARLY_EXIT_EN
        e.lat = (k < NBYTES) ? k + 2 : NBYTES + 1;
`else
        e.lat = NBYTES + 1;
`endif
        e.hs_neg = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pushes expectations on input handshakes, pops and checks on results.
    logic rst_prev = 1'b0;
    logic seen = 1'b0;
    logic ohs_prev = 1'b0;
    logic ohs_now;
    logic have_prev = 1'b0;
    logic [2:0] held = 3'b000;
    int   prev_hs_neg = 0;
    int   prev_lat = 0;
    exp_t e;

    always @(negedge clk) begin
        neg_cnt++;
        if (!rst_prev) begin
            check("rst_outputs_u", {in_ready_u, out_valid_u, eq_u, gt_u, lt_u, busy_u}, 32'h20);
            check("rst_outputs_s", {in_ready_s, out_valid_s, eq_s, gt_s, lt_s, busy_s}, 32'h20);
        end else if (ohs_prev) begin
            check("idle_after_out", {in_ready_u, out_valid_u, busy_u}, 32'h4);
        end
        if (!rst_n) begin
            sb.delete();
            seen      = 1'b0;
            have_prev = 1'b0;
            ohs_prev  = 1'b0;
        end else begin
            ohs_now = 1'b0;
            if (out_valid_u) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL stale_result: out_valid with no pending compare at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("result_u", {eq_u, gt_u, lt_u}, e.res_u);
                        check("result_s", {eq_s, gt_s, lt_s}, e.res_s);
                        check("latency", neg_cnt - e.hs_neg, e.lat);
                        check("out_valid_s", out_valid_s, 1);
                    end
                    held = {eq_u, gt_u, lt_u};
                    seen = 1'b1;
                end else begin
                    check("stall_hold", {eq_u, gt_u, lt_u}, held);
                    check("stall_ready_busy", {in_ready_u, busy_u}, 32'h1);
                end
                if (out_ready) begin
                    ohs_now = 1'b1;
                    seen    = 1'b0;
                end
            end
            if (in_valid && in_ready_u) begin
                e = model(a, b);
                e.hs_neg = neg_cnt;
                sb.push_back(e);
                hs_cnt++;
                if (tied) begin
                    if (have_prev) check("spacing", neg_cnt - prev_hs_neg, prev_lat + 1);
                    have_prev   = 1'b1;
                    prev_hs_neg = neg_cnt;
                    prev_lat    = e.lat;
                end else begin
                    have_prev = 1'b0;
                end
            end
            ohs_prev = ohs_now;
        end
        rst_prev = rst_n;
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv);
        int start;
        int t;
        start = hs_cnt;
        t = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        do begin
            @(posedge clk);
            t++;
        end while (hs_cnt == start && t < 50);
        #1;
        in_valid = 1'b0;
        a = $urandom();
        b = $urandom();
        if (hs_cnt == start) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no handshake expected one within 50 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(sb.size() == 0 && in_ready_u && !out_valid_u) && t < 60);
        if (t >= 60) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid_u && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid_u) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid_timeout: got out_valid 0 expected 1");
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int cyc;
        logic [31:0] ra;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(32'hDEADBEEF, 32'hDEADBEEF); drain();
        send(32'h12345678, 32'h12345679); drain();
        send(32'h80000000, 32'h7FFFFFFF); drain();
        send(32'h00000000, 32'hFFFFFFFF); drain();
        send(32'hFF000000, 32'h01000000); drain();
        send(32'h12340000, 32'h12350000); drain();
        send(32'hAB00CD01, 32'hAB00CD00); drain();

        // Consumer stall in DONE.
        out_ready = 1'b0;
        send(32'hA5A5A5A5, 32'h5A5A5A5A);
        wait_valid();
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset two edges after the handshake discards the pending compare.
        send(32'hCAFEF00D, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send(32'h00000001, 32'h80000000); drain();

        // Back-to-back random traffic with both handshakes tied high.
        tied = 1'b1;
        out_ready = 1'b1;
        target = hs_cnt + 1000;
        cyc = 0;
        a = $urandom();
        b = $urandom();
        in_valid = 1'b1;
        while (hs_cnt < target && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (hs_cnt >= target) break;
            ra = $urandom();
            a = ra;
            case ($urandom_range(0, 3))
                0: b = ra;
                1: b = ra ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom();
            endcase
        end
        in_valid = 1'b0;
        tied = 1'b0;
        if (hs_cnt < target) begin
            n_vec++;
            n_err++;
            $display("FAIL random_timeout: got %0d handshakes expected %0d", hs_cnt, target);
        end
        drain();

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
